writeback_stage: RTL and testbench
==================================

// Module: writeback_stage
// PURPOSE
//  Parametrised MEM/WB pipeline stage that generalises the old 2:1 MemtoReg mux.
//  Selects one of four writeback sources: ALU, memory, link (PC+4) or immediate.
//  Aligns and extends sub-word loads, then registers the result with stall/flush control.
//  Drives the register-file write port and the forwarding network.
// PARAMETERS
//  WIDTH       32  datapath width in bits; must be 32 or 64
//  REG_ADDR_W  5   register-file address width
//  OFF_W       $clog2(WIDTH/8)  byte-offset width (derived localparam, not overridable)
// PORTS
//  clock            in   1           single clock; all state updates on rising edge
//  reset            in   1           synchronous, active-high
//  stall            in   1           hold the WB register contents
//  flush            in   1           load a bubble (valid=0)
//  in_valid         in   1           MEM-stage instruction is valid
//  in_reg_write     in   1           instruction writes rd
//  in_rd            in   REG_ADDR_W  destination register
//  in_wb_sel        in   2           0=ALU 1=MEM 2=LINK 3=IMM
//  in_load_size     in   2           0=word(WIDTH) 1=half 2=byte 3=reserved (treated as word)
//  in_load_unsigned in   1           1=zero-extend, 0=sign-extend
//  in_byte_off      in   OFF_W       byte offset within the memory word (= address LSBs)
//  in_alu_result    in   WIDTH       ALU result
//  in_mem_data      in   WIDTH       raw data-memory read word
//  in_pc_plus4      in   WIDTH       link value
//  in_imm           in   WIDTH       pre-shifted immediate (LUI-style)
//  wb_valid         out  1           registered valid
//  wb_reg_write     out  1           register-file write enable
//  wb_rd            out  REG_ADDR_W  register-file write address
//  wb_data          out  WIDTH       register-file write data
//  wb_misalign      out  1           misaligned load retired this cycle
// BEHAVIOUR
//  - Clock and reset: one clock; reset is synchronous and active-high.
//    All outputs are 0 on the first edge with reset=1.
//  - Update priority on each edge: reset > flush > stall > load.
//    - flush: clears wb_valid, wb_reg_write and wb_misalign; wb_rd and wb_data are don't-care.
//    - stall (without flush): every output register holds its value.
//  - Latency: exactly 1 cycle from in_* to wb_*. No combinational path from in_* to outputs.
//  - Load alignment (wb_sel=MEM only):
//    - byte: field = in_mem_data[8*off +: 8].
//    - half: field = in_mem_data[16*off[OFF_W-1:1] +: 16].
//    - The field is zero- or sign-extended to WIDTH per in_load_unsigned.
//    - word: in_mem_data passes unchanged.
//  - Misalignment (wb_sel=MEM only):
//    - Misaligned if half with off[0]=1, or word with off!=0.
//    - A misaligned load registers wb_misalign=1 and forces wb_reg_write=0.
//    - wb_data then carries the unaligned raw word.
//  - Write-enable rule:
//    wb_reg_write = in_valid & in_reg_write & (in_rd!=0) & ~misalign, registered.
//  - in_valid=0 loads a bubble: wb_valid=0, wb_reg_write=0, wb_misalign=0.
//  - Non-MEM selections ignore load_size, load_unsigned and byte_off. They never set misalign.
//  - A stall asserted mid-flight holds the value indefinitely; the first unstalled edge loads
//    the current inputs.
//  - Reset asserted together with stall or flush: reset wins.
// STRUCTURE
//  - Shared header wb_defs.vh holds:
//    - WB_SEL_ALU/MEM/LINK/IMM (2'd0..3).
//    - LOAD_WORD/HALF/BYTE (2'd0..2).
//  - Sub-module load_align (combinational):
//    - Inputs: mem_data, size, unsigned, off.
//    - Outputs: aligned_data, misalign.
//    - Parametrised by WIDTH.
//  - Top level: 4:1 source mux plus one WB pipeline register bank with priority logic.
// TESTING
//  1. reset=1 with random inputs -> next edge: every output 0; holds while reset=1.
//  2. ALU path: wb_sel=0, alu=32'h0000_1234, rd=5, valid=1, reg_write=1
//     -> one edge later wb_data=32'h1234, wb_rd=5, wb_reg_write=1.
//  3. Byte load: mem=32'h80FF_7F01.
//     - off=3, signed -> 32'hFFFF_FF80.
//     - off=2, unsigned -> 32'h0000_00FF.
//     - half, off=2, signed -> 32'hFFFF_80FF.
//  4. Misaligned loads: half, off=1 -> wb_misalign=1, wb_reg_write=0.
//     Word, off=2 -> same result.
//  5. rd=0 with reg_write=1 -> wb_reg_write=0. LINK with pc_plus4=32'h0040_0008, rd=31
//     -> wb_data=32'h0040_0008.
//  6. Stall/flush:
//     - Load A, stall 3 cycles while inputs change -> outputs stay A.
//     - flush+stall together -> wb_valid=0.
//     - reset+flush together -> all 0.

Source files
------------

// File: rtl/writeback_stage_pkg.sv
// Shared constants for the MEM/WB writeback stage: source selects and load sizes.
package writeback_stage_pkg;

  // Writeback source select encodings
  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_MEM  = 2'd1;
  localparam logic [1:0] WB_SEL_LINK = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

  // Load size encodings; 2'd3 is reserved and behaves like a full-width word
  localparam logic [1:0] LOAD_WORD = 2'd0;
  localparam logic [1:0] LOAD_HALF = 2'd1;
  localparam logic [1:0] LOAD_BYTE = 2'd2;
  localparam logic [1:0] LOAD_RSVD = 2'd3;

  // True when the selected writeback source is the data memory
  function automatic logic is_mem_sel(input logic [1:0] sel);
    return (sel == WB_SEL_MEM);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Bundle of MEM-stage inputs, pipeline control and WB-stage outputs.
// Handshake: there is no backpressure; in_valid qualifies the in_* fields on
// each rising edge, stall holds the WB register, flush inserts a bubble, and
// wb_valid qualifies the wb_* fields for the cycle after they were captured.
interface writeback_stage_if #(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
);
  localparam int OFF_W = $clog2(WIDTH / 8);

  logic                  stall;
  logic                  flush;
  logic                  in_valid;
  logic                  in_reg_write;
  logic [REG_ADDR_W-1:0] in_rd;
  logic [1:0]            in_wb_sel;
  logic [1:0]            in_load_size;
  logic                  in_load_unsigned;
  logic [OFF_W-1:0]      in_byte_off;
  logic [WIDTH-1:0]      in_alu_result;
  logic [WIDTH-1:0]      in_mem_data;
  logic [WIDTH-1:0]      in_pc_plus4;
  logic [WIDTH-1:0]      in_imm;
  logic                  wb_valid;
  logic                  wb_reg_write;
  logic [REG_ADDR_W-1:0] wb_rd;
  logic [WIDTH-1:0]      wb_data;
  logic                  wb_misalign;

  // Upstream pipeline / test driver side
  modport master (
    output stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel,
           in_load_size, in_load_unsigned, in_byte_off, in_alu_result,
           in_mem_data, in_pc_plus4, in_imm,
    input  wb_valid, wb_reg_write, wb_rd, wb_data, wb_misalign
  );

  // Writeback stage side
  modport slave (
    input  stall, flush, in_valid, in_reg_write, in_rd, in_wb_sel,
           in_load_size, in_load_unsigned, in_byte_off, in_alu_result,
           in_mem_data, in_pc_plus4, in_imm,
    output wb_valid, wb_reg_write, wb_rd, wb_data, wb_misalign
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational sub-word load alignment: extracts byte/half fields from the
// raw memory word, extends them, and flags misaligned accesses.
module writeback_stage_load_align
  import writeback_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]              i_mem_data,
  input  logic [1:0]                    i_size,
  input  logic                          i_unsigned,
  input  logic [$clog2(WIDTH/8)-1:0]    i_off,
  output logic [WIDTH-1:0]              o_aligned_data,
  output logic                          o_misalign
);

  localparam int OFF_W = $clog2(WIDTH / 8);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [OFF_W+2:0] w_byte_base;
  logic [OFF_W+2:0] w_half_base;

  // Bit positions of the addressed byte and of the enclosing aligned halfword
  assign w_byte_base = {i_off, 3'b000};
  assign w_half_base = {i_off[OFF_W-1:1], 4'b0000};
  assign w_byte      = i_mem_data[w_byte_base +: 8];
  assign w_half      = i_mem_data[w_half_base +: 16];

  // Select and extend the field; misaligned accesses pass the raw word through
  always_comb begin
    o_aligned_data = i_mem_data;
    o_misalign     = 1'b0;
    case (i_size)
      LOAD_BYTE: begin
        o_aligned_data = {{(WIDTH-8){w_byte[7] & ~i_unsigned}}, w_byte};
      end
      LOAD_HALF: begin
        if (i_off[0]) begin
          o_misalign = 1'b1;
        end else begin
          o_aligned_data = {{(WIDTH-16){w_half[15] & ~i_unsigned}}, w_half};
        end
      end
      default: begin
        // Word and reserved size: full width, must be naturally aligned
        o_misalign = (i_off != '0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// MEM/WB pipeline stage: 4:1 writeback source mux, load alignment and a
// single registered output bank with reset > flush > stall > load priority.
module writeback_stage
  import writeback_stage_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  writeback_stage_if.slave  bus
);

  localparam int OFF_W = $clog2(WIDTH / 8);

  logic [WIDTH-1:0]      w_aligned;
  logic                  w_align_mis;
  logic                  w_is_mem;
  logic                  w_misalign;
  logic                  w_reg_write;
  logic [WIDTH-1:0]      w_wb_data;

  logic                  r_valid;
  logic                  r_reg_write;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [WIDTH-1:0]      r_data;
  logic                  r_misalign;

  writeback_stage_load_align #(
    .WIDTH (WIDTH)
  ) u_load_align (
    .i_mem_data     (bus.in_mem_data),
    .i_size         (bus.in_load_size),
    .i_unsigned     (bus.in_load_unsigned),
    .i_off          (bus.in_byte_off[OFF_W-1:0]),
    .o_aligned_data (w_aligned),
    .o_misalign     (w_align_mis)
  );

  assign w_is_mem    = is_mem_sel(bus.in_wb_sel);
  // Only memory loads can be misaligned; bubbles never report it
  assign w_misalign  = bus.in_valid & w_is_mem & w_align_mis;
  assign w_reg_write = bus.in_valid & bus.in_reg_write &
                       (bus.in_rd != '0) & ~w_misalign;

  // Writeback source mux
  always_comb begin
    w_wb_data = bus.in_alu_result;
    case (bus.in_wb_sel)
      WB_SEL_ALU:  w_wb_data = bus.in_alu_result;
      WB_SEL_MEM:  w_wb_data = w_aligned;
      WB_SEL_LINK: w_wb_data = bus.in_pc_plus4;
      WB_SEL_IMM:  w_wb_data = bus.in_imm;
      default:     w_wb_data = bus.in_alu_result;
    endcase
  end

  // WB register bank; flush only needs to kill the qualifying flags
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
      r_misalign  <= 1'b0;
    end else if (bus.flush) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_misalign  <= 1'b0;
    end else if (!bus.stall) begin
      r_valid     <= bus.in_valid;
      r_reg_write <= w_reg_write;
      r_rd        <= bus.in_rd;
      r_data      <= w_wb_data;
      r_misalign  <= w_misalign;
    end
  end

  assign bus.wb_valid     = r_valid;
  assign bus.wb_reg_write = r_reg_write;
  assign bus.wb_rd        = r_rd;
  assign bus.wb_data      = r_data;
  assign bus.wb_misalign  = r_misalign;

endmodule

// File: tb/tb_writeback_stage.sv
// Randomized scoreboard bench for writeback_stage (WIDTH=32).
module tb_writeback_stage;

  localparam int W  = 32;
  localparam int RW = 5;

  typedef struct packed {
    logic          known;
    logic          valid;
    logic          we;
    logic          mis;
    logic [RW-1:0] rd;
    logic [W-1:0]  data;
  } exp_t;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;
  exp_t exp_q[$];
  exp_t model;

  writeback_stage_if #(.WIDTH(W), .REG_ADDR_W(RW)) bus ();

  writeback_stage #(.WIDTH(W), .REG_ADDR_W(RW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset block
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference load semantics written as plain arithmetic on the raw word
  task automatic ref_load(input logic [W-1:0] mem, input int size, input bit uns,
                          input int off, output logic [W-1:0] data, output bit mis);
    longint v;
    mis  = 0;
    data = mem;
    if (size == 2) begin
      v = (longint'(mem) >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v - 256;
      data = W'(v);
    end else if (size == 1) begin
      if (off % 2 == 1) mis = 1;
      else begin
        v = (longint'(mem) >> (16 * (off / 2))) % 65536;
        if (!uns && v >= 32768) v = v - 65536;
        data = W'(v);
      end
    end else begin
      mis = (off != 0);
    end
  endtask

  // Advance the model by one clock edge from the currently driven inputs
  task automatic model_edge();
    logic [W-1:0] ld;
    bit ld_mis;
    if (reset) begin
      model = '0;
      model.known = 1'b1;
    end else if (bus.flush) begin
      model.valid = 0; model.we = 0; model.mis = 0; model.known = 0;
    end else if (bus.stall) begin
      model = model;
    end else if (!bus.in_valid) begin
      model.valid = 0; model.we = 0; model.mis = 0; model.known = 0;
    end else begin
      ref_load(bus.in_mem_data, int'(bus.in_load_size), bus.in_load_unsigned,
               int'(bus.in_byte_off), ld, ld_mis);
      model.known = 1;
      model.valid = 1;
      model.rd    = bus.in_rd;
      case (int'(bus.in_wb_sel))
        0: begin model.data = bus.in_alu_result; model.mis = 0; end
        1: begin model.data = ld;                model.mis = ld_mis; end
        2: begin model.data = bus.in_pc_plus4;   model.mis = 0; end
        default: begin model.data = bus.in_imm;  model.mis = 0; end
      endcase
      model.we = bus.in_reg_write && (bus.in_rd != 0) && !model.mis;
    end
  endtask

  // Driver: issue the current inputs across one edge, push the expectation
  task automatic step();
    model_edge();
    exp_q.push_back(model);
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rand_inputs();
    bus.in_valid         = 1'($urandom_range(0, 1));
    bus.in_reg_write     = 1'($urandom_range(0, 1));
    bus.in_rd            = RW'($urandom_range(0, 31));
    bus.in_wb_sel        = 2'($urandom_range(0, 3));
    bus.in_load_size     = 2'($urandom_range(0, 3));
    bus.in_load_unsigned = 1'($urandom_range(0, 1));
    bus.in_byte_off      = 2'($urandom_range(0, 3));
    bus.in_alu_result    = $urandom;
    bus.in_mem_data      = $urandom;
    bus.in_pc_plus4      = $urandom;
    bus.in_imm           = $urandom;
  endtask

  task automatic set_op(input bit v, input bit we, input int rd, input int sel,
                        input int size, input bit uns, input int off);
    bus.in_valid         = v;
    bus.in_reg_write     = we;
    bus.in_rd            = RW'(rd);
    bus.in_wb_sel        = 2'(sel);
    bus.in_load_size     = 2'(size);
    bus.in_load_unsigned = uns;
    bus.in_byte_off      = 2'(off);
  endtask

  // Monitor: compare every registered output against the oldest expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("valid",    64'(bus.wb_valid),     64'(e.valid));
        check("reg_write", 64'(bus.wb_reg_write), 64'(e.we));
        check("misalign", 64'(bus.wb_misalign),  64'(e.mis));
        if (e.known) begin
          check("rd",   64'(bus.wb_rd),   64'(e.rd));
          check("data", 64'(bus.wb_data), 64'(e.data));
        end
      end
    end
  end

  // Stimulus sequence
  initial begin
    n_cmp = 0;
    n_fail = 0;
    model = '0;
    reset = 1'b1;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    rand_inputs();

    // Reset with random inputs, held for several edges
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      bus.stall = 1'($urandom_range(0, 1));
      bus.flush = 1'($urandom_range(0, 1));
      step();
      check("rst_data", 64'(bus.wb_data), 64'h0);
      check("rst_flags", 64'({bus.wb_valid, bus.wb_reg_write, bus.wb_misalign, bus.wb_rd}), 64'h0);
    end
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;

    // ALU path
    rand_inputs();
    set_op(1, 1, 5, 0, 0, 0, 0);
    bus.in_alu_result = 32'h0000_1234;
    step();
    check("alu_data", 64'(bus.wb_data), 64'h1234);
    check("alu_rd", 64'(bus.wb_rd), 64'd5);
    check("alu_we", 64'(bus.wb_reg_write), 64'd1);

    // Sub-word loads
    bus.in_mem_data = 32'h80FF_7F01;
    set_op(1, 1, 3, 1, 2, 0, 3);
    step();
    check("lb_off3", 64'(bus.wb_data), 64'hFFFF_FF80);
    set_op(1, 1, 3, 1, 2, 1, 2);
    step();
    check("lbu_off2", 64'(bus.wb_data), 64'h0000_00FF);
    set_op(1, 1, 3, 1, 1, 0, 2);
    step();
    check("lh_off2", 64'(bus.wb_data), 64'hFFFF_80FF);

    // Misaligned loads
    set_op(1, 1, 3, 1, 1, 0, 1);
    step();
    check("lh_mis", 64'({bus.wb_misalign, bus.wb_reg_write}), 64'b10);
    check("lh_mis_raw", 64'(bus.wb_data), 64'h80FF_7F01);
    set_op(1, 1, 3, 1, 0, 0, 2);
    step();
    check("lw_mis", 64'({bus.wb_misalign, bus.wb_reg_write}), 64'b10);

    // rd=0 and link
    set_op(1, 1, 0, 0, 0, 0, 0);
    step();
    check("rd0_we", 64'(bus.wb_reg_write), 64'd0);
    set_op(1, 1, 31, 2, 3, 0, 1);
    bus.in_pc_plus4 = 32'h0040_0008;
    step();
    check("link_data", 64'(bus.wb_data), 64'h0040_0008);
    check("link_we", 64'({bus.wb_misalign, bus.wb_reg_write}), 64'b01);

    // Stall holds A while inputs change
    set_op(1, 1, 7, 0, 0, 0, 0);
    bus.in_alu_result = 32'hAAAA_0001;
    step();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      step();
      check("stall_data", 64'(bus.wb_data), 64'hAAAA_0001);
      check("stall_rd", 64'(bus.wb_rd), 64'd7);
    end
    bus.flush = 1'b1;
    step();
    check("flush_stall_valid", 64'(bus.wb_valid), 64'd0);
    reset = 1'b1;
    step();
    check("rst_flush", 64'({bus.wb_valid, bus.wb_reg_write, bus.wb_misalign, bus.wb_rd, bus.wb_data}), 64'h0);
    reset = 1'b0;
    bus.flush = 1'b0;
    bus.stall = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      bus.stall = ($urandom_range(0, 99) < 20);
      bus.flush = ($urandom_range(0, 99) < 8);
      reset     = ($urandom_range(0, 99) < 3);
      step();
    end
    reset = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    @(posedge clock);
    #2;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL queue_drain: %0d left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
